// File: rtl/bayer_mosaic.sv
// Re-mosaics raster-order ARGB pixels into an RGGB Bayer sample stream.
// Four consecutive 8-bit samples are packed per output word, oldest sample in the MSBs.
module bayer_mosaic #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pixel,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_eof,
  output logic        frame_err
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   pend_q, pend_d;
  logic [31:0]   data_q, data_d;
  logic          vld_q, vld_d;
  logic          eof_q, eof_d;
  logic          err_q, err_d;

  logic          accept;
  logic [CW-1:0] ecol;
  logic [RW-1:0] erow;
  logic [1:0]    elane;
  logic [7:0]    sample;
  logic          unused_alpha;

  assign unused_alpha = ^in_pixel[31:24];

  always_comb begin
    in_ready = (lane_q != 2'd3) || !vld_q || out_ready;
    accept   = in_valid && in_ready;

    // in_sof relocates the incoming pixel to the frame origin
    ecol  = in_sof ? '0   : col_q;
    erow  = in_sof ? '0   : row_q;
    elane = in_sof ? 2'd0 : lane_q;

    case ({erow[0], ecol[0]})
      2'b00:   sample = in_pixel[23:16];
      2'b11:   sample = in_pixel[7:0];
      default: sample = in_pixel[15:8];
    endcase

    col_d  = col_q;
    row_d  = row_q;
    lane_d = lane_q;
    pend_d = pend_q;
    data_d = data_q;
    vld_d  = vld_q;
    eof_d  = eof_q;
    err_d  = 1'b0;

    if (vld_q && out_ready) vld_d = 1'b0;

    if (accept) begin
      err_d = in_sof && ((col_q != '0) || (row_q != '0) || (lane_q != 2'd0));

      if (elane == 2'd3) begin
        // lane 3 is never reached on an sof pixel, so pend_q is all fresh
        data_d = {pend_q, sample};
        vld_d  = 1'b1;
        eof_d  = (ecol == COL_LAST) && (erow == ROW_LAST);
        lane_d = 2'd0;
      end else begin
        pend_d = in_sof ? {16'h0, sample} : {pend_q[15:0], sample};
        lane_d = elane + 2'd1;
      end

      if (ecol == COL_LAST) begin
        col_d = '0;
        row_d = (erow == ROW_LAST) ? '0 : erow + RW'(1);
      end else begin
        col_d = ecol + CW'(1);
        row_d = erow;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      lane_q <= 2'd0;
      pend_q <= 24'h0;
      data_q <= 32'h0;
      vld_q  <= 1'b0;
      eof_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      lane_q <= lane_d;
      pend_q <= pend_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      eof_q  <= eof_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_eof   = eof_q;
  assign frame_err = err_q;

endmodule

// File: doc/bayer_mosaic.md
# bayer_mosaic

Streaming re-mosaic block: accepts ARGB pixels in raster order and produces the RGGB Bayer intensity stream the sensor would have delivered. It keeps one 8-bit sample per pixel, selected by row/column parity, and packs four consecutive samples into a 32-bit word for the frame-buffer writer. It sits on the render/output side of the pipeline and produces synthetic sensor frames for the capture path.

## Interface
- WIDTH, 640, active pixels per line; must be a multiple of 4 and ≥ 4
- HEIGHT, 480, lines per frame; ≥ 1
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_pixel/in_sof valid this cycle
- in_ready  out  1  block accepts pixel this cycle
- in_pixel  in  32  {A[31:24], R[23:16], G[15:8], B[7:0]}; A ignored
- in_sof  in  1  qualifies in_pixel as first pixel of a frame
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  downstream accepts word
- out_data  out  32  four Bayer samples, oldest in [31:24], newest in [7:0]
- out_eof  out  1  qualifies out_data as last word of frame
- frame_err  out  1  one-cycle pulse: in_sof arrived mid-frame

## Operation
- Input handshake: a pixel is accepted when in_valid && in_ready. Output handshake: a word leaves when out_valid && out_ready.
- State: col counter (0..WIDTH-1), row counter (0..HEIGHT-1), lane counter (0..3), 24-bit pending sample register, output word register, out_eof register.
- Sample select on the accepted pixel: row even / col even → R; row even / col odd → G; row odd / col even → G; row odd / col odd → B.
- Lanes 0–2: the sample goes into the pending register and lane increments.
- Lane 3: {pending, sample} loads out_data. out_valid is set. out_eof is set iff col = WIDTH-1 and row = HEIGHT-1. Lane returns to 0.
- Counters: col increments per accepted pixel. At WIDTH-1, col wraps to 0 and row increments. At (WIDTH-1, HEIGHT-1), both wrap to 0.
- in_ready = (lane != 3) || !out_valid || out_ready. Lanes 0–2 never stall.
- in_sof on an accepted pixel forces that pixel to position (0,0), lane 0. Counters and lane then advance from there.
  - If col, row or lane were nonzero at that point, frame_err pulses the next cycle and pending samples are discarded.
  - out_data is unaffected if already valid.
- After reset, a frame may start without in_sof; the first pixel is (0,0).
- While out_valid && !out_ready, out_data and out_eof hold stable.
- Simultaneous drain and lane-3 load: the new word replaces the old one and out_valid stays 1.
- Drain with no load: out_valid clears.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_eof 0, frame_err 0. Counters, lane and pending register are 0.
- Latency: out_valid asserts the cycle after the lane-3 pixel is accepted.
- Throughput: 1 pixel/cycle sustained with out_ready held high, i.e. one word every 4 cycles.
- frame_err is registered and asserts for exactly one cycle after the offending in_sof pixel is accepted.
- Reset asserted mid-frame: all state clears immediately (asynchronous). The partial word and the pending out_data are lost.
- Counter widths: $clog2(WIDTH) and $clog2(HEIGHT), with no overflow beyond the wrap points.

## Test plan
- Reset: drive n_rst=0 mid-stream → in_ready=1, out_valid=0, out_data=0, out_eof=0, frame_err=0 with no clock edge needed.
- WIDTH=4, HEIGHT=2, 8 pixels of 0xFF112233, in_sof on the first, out_ready=1:
  - first word out_data=0x11221122, out_eof=0;
  - second word 0x22332233, out_eof=1;
  - the next pixel maps to (0,0) again.
- Backpressure: out_ready=0 after the first word → in_ready drops at lane 3 of the second word. out_data holds 0x11221122 until out_ready=1, then 0x22332233 follows the next cycle.
- Mid-frame sof: 2 pixels, then a pixel of 0xFF445566 with in_sof → frame_err pulses one cycle. With 3 more pixels of 0xFF445566, out_data=0x44554455 and no stale samples appear.
- Full throughput: 16 back-to-back pixels with out_ready=1 → exactly 4 words, spaced 4 cycles apart, in_ready constantly 1, out_valid never deasserting between loads and drains.
- Reset mid-word: after 2 pixels assert n_rst=0, then release and send 4 pixels of 0xFF112233 → a single word 0x11221122 with no frame_err.
